// File: rtl/sopc_motor_fb_pkg.sv
// Shared register map, bit positions and channel address decode for the
// motor feedback capture slave.
package sopc_motor_fb_pkg;

  localparam int unsigned ADDR_CTRL      = 0;
  localparam int unsigned ADDR_PERIOD    = 1;
  localparam int unsigned ADDR_STATUS    = 2;
  localparam int unsigned ADDR_CMD       = 3;
  localparam int unsigned ADDR_SNAP_BASE = 4;
  localparam int unsigned ADDR_CH_STRIDE = 2;

  localparam int unsigned CTRL_AUTO_EN     = 0;
  localparam int unsigned CTRL_IRQ_EN      = 1;
  localparam int unsigned STATUS_SNAP_DONE = 0;
  localparam int unsigned STATUS_OVERRUN   = 1;
  localparam int unsigned CMD_SNAP         = 0;

  typedef struct packed {
    logic       hit;
    logic       is_delta;
    logic [2:0] ch;
  } ch_sel_t;

  // Each channel owns a SNAP/DELTA word pair starting at ADDR_SNAP_BASE.
  function automatic ch_sel_t ch_decode(input logic [31:0] addr, input int unsigned n_ch);
    ch_sel_t     sel;
    logic [31:0] off;
    sel = '0;
    off = addr - ADDR_SNAP_BASE;
    if (addr >= ADDR_SNAP_BASE && off < ADDR_CH_STRIDE * n_ch) begin
      sel.hit      = 1'b1;
      sel.is_delta = 1'(off);
      sel.ch       = 3'(off >> 1);
    end
    return sel;
  endfunction

endpackage

// File: rtl/sopc_motor_fb_period_timer.sv
// Auto-snapshot period timer: load, count down, fire at zero and reload.
module sopc_motor_fb_period_timer #(
  parameter int unsigned PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] load_val,
  input  logic [PERIOD_W-1:0] period,
  output logic                fire
);

  logic [PERIOD_W-1:0] timer_q;
  logic                running;

  assign running = enable && (period != '0);
  assign fire    = running && (timer_q == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q <= '0;
    end else if (load) begin
      timer_q <= load_val;
    end else if (running) begin
      timer_q <= fire ? period : timer_q - PERIOD_W'(1);
    end
  end

endmodule

// File: rtl/sopc_motor_fb_capture.sv
// Multi-channel encoder snapshot slave: coherent capture of all channels with
// per-channel delta, manual or periodic trigger, level irq and overrun flag.
module sopc_motor_fb_capture
  import sopc_motor_fb_pkg::*;
#(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned CH_W     = 16,
  parameter int unsigned PERIOD_W = 24,
  parameter int unsigned ADDR_W   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADDR_W-1:0]      address,
  input  logic                   chipselect,
  input  logic                   write_n,
  input  logic [31:0]            writedata,
  input  logic [N_CH*CH_W-1:0]   in_port,
  output logic [31:0]            readdata,
  output logic                   irq
);

  logic [31:0]         addr32;
  logic                wr_en, wr_ctrl, wr_period, wr_status, wr_cmd;
  logic                timer_load, fire, manual, snap_evt, clr_done, clr_ovr;
  logic [PERIOD_W-1:0] load_val;
  logic [1:0]          ctrl_q;
  logic [PERIOD_W-1:0] period_q;
  logic                snap_done_q, overrun_q;
  logic [CH_W-1:0]     ch_in   [N_CH];
  logic [CH_W-1:0]     snap_q  [N_CH];
  logic [CH_W-1:0]     delta_q [N_CH];
  logic [31:0]         rd_mux;
  ch_sel_t             sel;
  logic                unused_wd;

  assign addr32    = 32'(address);
  assign wr_en     = chipselect && !write_n;
  assign wr_ctrl   = wr_en && (addr32 == ADDR_CTRL);
  assign wr_period = wr_en && (addr32 == ADDR_PERIOD);
  assign wr_status = wr_en && (addr32 == ADDR_STATUS);
  assign wr_cmd    = wr_en && (addr32 == ADDR_CMD);
  assign unused_wd = ^writedata;

  assign manual   = wr_cmd && writedata[CMD_SNAP];
  assign snap_evt = manual || fire;
  assign clr_done = wr_status && writedata[STATUS_SNAP_DONE];
  assign clr_ovr  = wr_status && writedata[STATUS_OVERRUN];

  // A PERIOD write reloads with the value being written, not the stale register.
  assign timer_load = wr_period || (wr_ctrl && writedata[CTRL_AUTO_EN]);
  assign load_val   = wr_period ? writedata[PERIOD_W-1:0] : period_q;

  sopc_motor_fb_period_timer #(
    .PERIOD_W (PERIOD_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .enable   (ctrl_q[CTRL_AUTO_EN]),
    .load_val (load_val),
    .period   (period_q),
    .fire     (fire)
  );

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    assign ch_in[g] = in_port[g*CH_W +: CH_W];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q      <= '0;
      period_q    <= '0;
      snap_done_q <= 1'b0;
      overrun_q   <= 1'b0;
      for (int unsigned i = 0; i < N_CH; i++) begin
        snap_q[i]  <= '0;
        delta_q[i] <= '0;
      end
    end else begin
      if (wr_ctrl)
        ctrl_q <= {writedata[CTRL_IRQ_EN], writedata[CTRL_AUTO_EN]};
      if (wr_period)
        period_q <= writedata[PERIOD_W-1:0];
      // A snapshot beats a same-cycle clear of snap_done and then is not an overrun.
      if (snap_evt)
        snap_done_q <= 1'b1;
      else if (clr_done)
        snap_done_q <= 1'b0;
      if (snap_evt && snap_done_q && !clr_done)
        overrun_q <= 1'b1;
      else if (clr_ovr)
        overrun_q <= 1'b0;
      if (snap_evt) begin
        for (int unsigned i = 0; i < N_CH; i++) begin
          snap_q[i]  <= ch_in[i];
          delta_q[i] <= ch_in[i] - snap_q[i];
        end
      end
    end
  end

  assign sel = ch_decode(addr32, N_CH);

  always_comb begin
    rd_mux = '0;
    case (addr32)
      ADDR_CTRL:   rd_mux = 32'(ctrl_q);
      ADDR_PERIOD: rd_mux = 32'(period_q);
      ADDR_STATUS: rd_mux = 32'({overrun_q, snap_done_q});
      default: begin
        if (sel.hit) begin
          for (int unsigned i = 0; i < N_CH; i++) begin
            if (sel.ch == 3'(i))
              rd_mux = sel.is_delta ? 32'(signed'(delta_q[i])) : 32'(snap_q[i]);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      readdata <= '0;
    else
      readdata <= rd_mux;
  end

  assign irq = ctrl_q[CTRL_IRQ_EN] & snap_done_q;

endmodule

// File: tb/tb_sopc_motor_fb_capture.sv
// Scoreboard bench for sopc_motor_fb_capture: directed scenarios followed by
// randomized bus traffic, checked against a cycle-indexed behavioural model.
module tb_sopc_motor_fb_capture;

  localparam int unsigned N_CH     = 4;
  localparam int unsigned CH_W     = 16;
  localparam int unsigned PERIOD_W = 24;
  localparam int unsigned ADDR_W   = 4;
  localparam logic [31:0] CH_MASK  = (CH_W == 32) ? 32'hFFFF_FFFF : ((32'd1 << CH_W) - 32'd1);
  localparam logic [31:0] PER_MASK = (32'd1 << PERIOD_W) - 32'd1;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [ADDR_W-1:0]    address = '0;
  logic                 chipselect = 1'b0;
  logic                 write_n = 1'b1;
  logic [31:0]          writedata = '0;
  logic [N_CH*CH_W-1:0] in_port = '0;
  logic [31:0]          readdata;
  logic                 irq;

  sopc_motor_fb_capture #(
    .N_CH     (N_CH),
    .CH_W     (CH_W),
    .PERIOD_W (PERIOD_W),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic        rd_vld_d;

  // Behavioural model: auto snapshots happen on edges anchor + k*(PERIOD+1).
  logic [1:0]           m_ctrl;
  int unsigned          m_period;
  logic                 m_done, m_ovr;
  logic [31:0]          m_snap  [N_CH];
  logic [31:0]          m_delta [N_CH];
  int unsigned          cyc, anchor;
  logic [N_CH*CH_W-1:0] cur_in = '0;

  function automatic void m_reset();
    m_ctrl = '0; m_period = 0; m_done = 1'b0; m_ovr = 1'b0;
    cyc = 0; anchor = 0;
    for (int c = 0; c < N_CH; c++) begin
      m_snap[c] = '0; m_delta[c] = '0;
    end
  endfunction

  function automatic logic m_fire_now();
    return m_ctrl[0] && (m_period != 0) && (cyc > anchor) &&
           (((cyc - anchor) % (m_period + 1)) == 0);
  endfunction

  function automatic logic [31:0] sext(input logic [31:0] v);
    if ((v & (32'd1 << (CH_W - 1))) != 0) return v | ~CH_MASK;
    return v;
  endfunction

  function automatic logic [31:0] m_read(input int unsigned a);
    int unsigned c;
    if (a == 0) return 32'(m_ctrl);
    if (a == 1) return 32'(m_period);
    if (a == 2) return {30'd0, m_ovr, m_done};
    if (a >= 4 && a < 4 + 2 * N_CH) begin
      c = (a - 4) / 2;
      return ((a - 4) % 2 == 0) ? m_snap[c] : sext(m_delta[c]);
    end
    return '0;
  endfunction

  function automatic void m_step(input logic wr, input int unsigned a, input logic [31:0] wd,
                                 input logic [N_CH*CH_W-1:0] inp);
    logic        evt, clr_d, clr_o;
    logic [31:0] nv;
    evt   = m_fire_now() || (wr && a == 3 && wd[0]);
    clr_d = wr && a == 2 && wd[0];
    clr_o = wr && a == 2 && wd[1];
    if (clr_o) m_ovr = 1'b0;
    if (evt && m_done && !clr_d) m_ovr = 1'b1;
    if (evt) m_done = 1'b1;
    else if (clr_d) m_done = 1'b0;
    if (evt) begin
      for (int c = 0; c < N_CH; c++) begin
        nv = 32'(inp >> (c * CH_W)) & CH_MASK;
        m_delta[c] = (nv - m_snap[c]) & CH_MASK;
        m_snap[c]  = nv;
      end
    end
    if (wr && a == 0) begin
      m_ctrl = wd[1:0];
      if (wd[0]) anchor = cyc;
    end
    if (wr && a == 1) begin
      m_period = int'(wd & PER_MASK);
      anchor   = cyc;
    end
    cyc++;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) rd_vld_d <= 1'b0;
    else       rd_vld_d <= chipselect && write_n;
  end

  // Monitor: compares each presented read result and the irq level every cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (rd_vld_d) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL readdata: got 0x%08h with no expected entry queued", readdata);
        end else begin
          check("readdata", readdata, exp_q.pop_front());
        end
      end
      check("irq", 32'(irq), 32'(m_ctrl[1] & m_done));
    end
  end

  task automatic tick(input logic cs, input logic wn, input logic [ADDR_W-1:0] a, input logic [31:0] wd);
    chipselect = cs; write_n = wn; address = a; writedata = wd; in_port = cur_in;
    if (cs && wn) exp_q.push_back(m_read(32'(a)));
    @(posedge clk);
    m_step(cs && !wn, 32'(a), wd, cur_in);
    @(negedge clk);
  endtask

  task automatic wr(input int unsigned a, input logic [31:0] d);
    tick(1'b1, 1'b0, ADDR_W'(a), d);
  endtask

  task automatic rd(input int unsigned a);
    tick(1'b1, 1'b1, ADDR_W'(a), $urandom);
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) tick(1'b0, 1'($urandom), ADDR_W'($urandom), $urandom);
  endtask

  task automatic set_ch(input int unsigned c, input logic [CH_W-1:0] v);
    cur_in[c*CH_W +: CH_W] = v;
  endtask

  task automatic wait_fire(input string name);
    int n = 0;
    while (!m_fire_now() && n < 200) begin
      idle(1);
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL %s: no auto snapshot within %0d cycles", name, n);
    end
  endtask

  task automatic do_reset();
    chipselect = 1'b1; write_n = 1'b1; address = ADDR_W'(4);
    @(posedge clk);
    m_step(1'b0, 4, '0, cur_in);
    #2 reset = 1'b1;
    #1;
    check("rst_readdata", readdata, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    m_reset();
    exp_q.delete();
    chipselect = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned op;
    m_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int unsigned a = 0; a < 16; a++) rd(a);

    // Manual snapshots, negative delta and overrun
    set_ch(0, 16'h0010); wr(3, 32'h1); rd(4); rd(5);
    set_ch(0, 16'h0005); wr(3, 32'h1); rd(5); rd(2);
    wr(2, 32'h3);

    // Counter wrap on channel 1
    set_ch(1, 16'hFFF0); wr(3, 32'h1);
    set_ch(1, 16'h0010); wr(3, 32'h1); rd(6); rd(7);
    wr(2, 32'h3);

    // Auto mode: PERIOD=9 gives a snapshot every 10 cycles
    wr(1, 32'd9); wr(0, 32'h3);
    idle(12); rd(2);
    idle(10); rd(2);
    wr(2, 32'h3); rd(2);

    // Status clear colliding with an auto snapshot
    wait_fire("fire_a"); idle(1); wr(2, 32'h2);
    wait_fire("fire_b"); wr(2, 32'h1); rd(2);

    // Manual command colliding with an auto snapshot
    wait_fire("fire_c");
    for (int unsigned c = 0; c < N_CH; c++) set_ch(c, CH_W'($urandom));
    wr(3, 32'h1);
    for (int unsigned c = 0; c < N_CH; c++) begin rd(4 + 2 * c); rd(5 + 2 * c); end
    wr(2, 32'h3);

    // Unmapped addresses and writes there
    rd(4 + 2 * N_CH); wr(13, 32'hFFFF_FFFF); rd(13); rd(15); rd(3);

    // PERIOD=0 with auto enabled never fires
    wr(1, 32'd0); wr(0, 32'h3); wr(2, 32'h3);
    idle(100); rd(2);

    do_reset();
    for (int unsigned a = 0; a < 16; a++) rd(a);

    // Randomized traffic
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 3) == 0)
        for (int unsigned c = 0; c < N_CH; c++) set_ch(c, CH_W'($urandom));
      if (i == 1200) do_reset();
      op = $urandom_range(0, 15);
      case (op)
        0, 1, 2, 3: rd($urandom_range(0, 15));
        4:          wr(3, $urandom);
        5:          wr(2, $urandom);
        6:          wr(0, $urandom);
        7:          wr(1, {8'($urandom), 24'($urandom_range(0, 14))});
        8:          wr($urandom_range(12, 15), $urandom);
        default:    idle(1);
      endcase
    end

    idle(2);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
